// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side and register-bank-side signals of the register file write arbiter.
// Handshake: a beat for requester i transfers in a cycle where req_valid[i] and
// req_ready[i] are both high; req_lock/req_addr/req_data are sampled with that beat.
interface regfile_wr_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 8
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ*AW-1:0]    req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [WIDTH-1:0]         wr_data;
    logic [GW-1:0]            grant_id;
    logic                     err_pulse;
    logic [7:0]               err_cnt;
    logic                     dbg_state;   // 1 while a requester holds the burst lock

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, grant_id, err_pulse, err_cnt, dbg_state
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, grant_id, err_pulse, err_cnt, dbg_state
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write arbiter in front of a register bank, with optional burst
// locking. Accepted beats are written one cycle later; out-of-range addresses
// are swallowed and counted instead of written.
module regfile_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_REGS  = 16,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int         AW         = $clog2(NUM_REGS);
    localparam int         GW         = $clog2(NUM_REQ);
    localparam logic       HAS_OOR    = (NUM_REGS != (1 << AW));
    localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);
    localparam logic [4:0] BURST_W    = 5'(MAX_BURST);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    owner_q, owner_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [GW-1:0]    grant_id_q, grant_id_d;
    logic             err_pulse_q, err_pulse_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [GW:0]        scan_sum;
    logic [GW-1:0]      scan_sel;
    logic               scan_hit;
    logic [GW-1:0]      sel;
    logic               accept;
    logic [NUM_REQ-1:0] ready;
    logic [AW-1:0]      sel_addr;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_lock;
    logic               sel_oor;
    logic [4:0]         cnt_inc;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        scan_hit = 1'b0;
        scan_sel = '0;
        scan_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (scan_sum >= (GW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (GW+1)'(NUM_REQ);
            end
            if (!scan_hit && bus.req_valid[scan_sum[GW-1:0]]) begin
                scan_hit = 1'b1;
                scan_sel = scan_sum[GW-1:0];
            end
        end
    end

    // Pick the granted requester: the lock owner while LOCKED, else the scan result.
    always_comb begin
        sel    = scan_sel;
        accept = scan_hit;
        if (state_q == LOCKED) begin
            sel    = owner_q;
            accept = bus.req_valid[owner_q];
        end
        accept = accept & rst_n;
        ready  = '0;
        if (accept) begin
            ready[sel] = 1'b1;
        end
    end

    // Route only the granted requester's lock/address/data into the datapath.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == GW'(i)) begin
                sel_addr = bus.req_addr[i*AW +: AW];
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
                sel_lock = bus.req_lock[i];
            end
        end
        sel_oor = HAS_OOR && ({1'b0, sel_addr} >= NUM_REGS_W);
    end

    // Next-state: lock entry/exit, round-robin pointer, write and error outputs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant_id_d  = grant_id_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        cnt_inc     = {1'b0, beat_cnt_q} + 5'd1;

        if (state_q == IDLE) begin
            if (accept && sel_lock && (MAX_BURST > 1)) begin
                state_d    = LOCKED;
                owner_d    = sel;
                beat_cnt_d = 4'd1;
            end
        end else begin
            if (!accept) begin
                // Owner went quiet: give up the lock without a beat.
                state_d    = IDLE;
                beat_cnt_d = '0;
            end else if (!sel_lock || (cnt_inc >= BURST_W)) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = cnt_inc[3:0];
            end
        end

        if (accept) begin
            rr_ptr_d   = (sel == GW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            grant_id_d = sel;
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
            if (sel_oor) begin
                err_pulse_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else begin
                wr_en_d = 1'b1;
            end
        end
    end

    // All state and registered outputs, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            grant_id_q  <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            grant_id_q  <= grant_id_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.dbg_state = (state_q == LOCKED);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus a randomized run
// against a behavioural model with an expected-write queue.
module tb_regfile_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int NUM_REGS  = 12;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int AW        = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [NUM_REQ-1:0] obs_ready;

    // behavioural model state
    int m_locked, m_owner, m_cnt, m_rr, m_err;
    logic [13:0] exp_q[$];

    regfile_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) bus ();

    regfile_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_locked = 0; m_owner = 0; m_cnt = 0; m_rr = 0; m_err = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_lock  = l;
        bus.req_addr  = a;
        bus.req_data  = d;
        #1;
        obs_ready = bus.req_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rules applied to one cycle of inputs; yields the expected
    // ready vector and what the write port should show after the edge.
    task automatic model_step(input logic [3:0] v, input logic [3:0] l, input logic [15:0] a, input logic [31:0] d,
                              output logic [3:0] er, output logic e_wr, output logic e_err, output int g);
        logic [3:0] ga;
        int idx;
        g = -1; er = '0; e_wr = 1'b0; e_err = 1'b0;
        if (m_locked != 0) begin
            if (v[m_owner[1:0]]) begin
                g = m_owner;
                m_cnt = m_cnt + 1;
                if (!l[g[1:0]] || m_cnt == MAX_BURST) m_locked = 0;
            end else begin
                m_locked = 0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_rr + k) % NUM_REQ;
                if (g < 0 && v[idx[1:0]]) g = idx;
            end
            if (g >= 0 && l[g[1:0]] && MAX_BURST > 1) begin
                m_locked = 1; m_owner = g; m_cnt = 1;
            end
        end
        if (g >= 0) begin
            er[g[1:0]] = 1'b1;
            m_rr = (g + 1) % NUM_REQ;
            ga = 4'(a >> (g * AW));
            if (int'(ga) >= NUM_REGS) begin
                e_err = 1'b1;
                if (m_err < 255) m_err = m_err + 1;
            end else begin
                e_wr = 1'b1;
                exp_q.push_back({2'(g), ga, 8'(d >> (g * 8))});
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_lock  = 4'b0000;
        bus.req_addr  = 16'h4321;
        bus.req_data  = 32'hD3C2B1A0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        n_checks++; if (bus.wr_addr !== 4'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
        n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %b want 0", bus.err_pulse); end
        n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
        n_checks++; if (bus.dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", bus.dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL release_ready: got %b want 0001", bus.req_ready); end
        tick();
        n_checks++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL release_wr_en: got %b want 1", bus.wr_en); end
        n_checks++; if (bus.wr_addr !== 4'h1) begin n_fail++; $display("FAIL release_wr_addr: got %h want 1", bus.wr_addr); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_r [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int eg;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b1111, 4'b0000, 16'h4321, 32'hD3C2B1A0);
            if (c == 0) begin
                n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_wr_en_before: got %b want 0", bus.wr_en); end
            end
            n_checks++; if (obs_ready !== exp_r[c]) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, obs_ready, exp_r[c]); end
            tick();
            eg = c % 4;
            n_checks++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL rr_wr_en[%0d]: got %b want 1", c, bus.wr_en); end
            n_checks++; if (bus.grant_id !== 2'(eg)) begin n_fail++; $display("FAIL rr_grant_id[%0d]: got %0d want %0d", c, bus.grant_id, eg); end
            n_checks++; if (bus.wr_addr !== 4'(eg + 1)) begin n_fail++; $display("FAIL rr_wr_addr[%0d]: got %h want %h", c, bus.wr_addr, eg + 1); end
            n_checks++; if (bus.wr_data !== 8'(8'hA0 + eg * 17)) begin n_fail++; $display("FAIL rr_wr_data[%0d]: got %h want %h", c, bus.wr_data, 8'hA0 + eg * 17); end
        end
        drive(4'b0000, 4'b0000, 16'h0, 32'h0);
        tick();
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_wr_en_idle: got %b want 0", bus.wr_en); end
    endtask

    task automatic test_lock_burst();
        apply_reset();
        drive(4'b0010, 4'b0000, 16'h0, 32'h0);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(4'b0111, 4'b0100, 16'h0567, 32'h00332211);
            n_checks++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL burst_ready[%0d]: got %b want 0100", c, obs_ready); end
            tick();
            n_checks++; if (bus.grant_id !== 2'd2 || bus.wr_en !== 1'b1 || bus.wr_data !== 8'h33 || bus.wr_addr !== 4'h5) begin
                n_fail++; $display("FAIL burst_write[%0d]: got id=%0d en=%b a=%h d=%h want id=2 en=1 a=5 d=33", c, bus.grant_id, bus.wr_en, bus.wr_addr, bus.wr_data);
            end
            n_checks++; if (bus.dbg_state !== (c < 3)) begin n_fail++; $display("FAIL burst_state[%0d]: got %b want %b", c, bus.dbg_state, c < 3); end
        end
        drive(4'b0111, 4'b0100, 16'h0567, 32'h00332211);
        n_checks++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL burst_after_ready: got %b want 0001", obs_ready); end
        tick();
        n_checks++; if (bus.grant_id !== 2'd0 || bus.wr_data !== 8'h11) begin n_fail++; $display("FAIL burst_after_write: got id=%0d d=%h want id=0 d=11", bus.grant_id, bus.wr_data); end
    endtask

    task automatic test_lock_drop();
        logic [3:0] v_t  [4] = '{4'b0111, 4'b0111, 4'b0101, 4'b0101};
        logic [3:0] l_t  [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0] er_t [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0100};
        logic       st_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       wr_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] id_t [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
        apply_reset();
        drive(4'b0001, 4'b0000, 16'h0, 32'h0);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(v_t[c], l_t[c], 16'h0321, 32'h00CCBBAA);
            n_checks++; if (obs_ready !== er_t[c]) begin n_fail++; $display("FAIL drop_ready[%0d]: got %b want %b", c, obs_ready, er_t[c]); end
            tick();
            n_checks++; if (bus.dbg_state !== st_t[c]) begin n_fail++; $display("FAIL drop_state[%0d]: got %b want %b", c, bus.dbg_state, st_t[c]); end
            n_checks++; if (bus.wr_en !== wr_t[c]) begin n_fail++; $display("FAIL drop_wr_en[%0d]: got %b want %b", c, bus.wr_en, wr_t[c]); end
            if (wr_t[c]) begin
                n_checks++; if (bus.grant_id !== id_t[c]) begin n_fail++; $display("FAIL drop_grant_id[%0d]: got %0d want %0d", c, bus.grant_id, id_t[c]); end
            end
        end
    endtask

    task automatic test_out_of_range();
        int wr_seen;
        int exp_cnt;
        apply_reset();
        drive(4'b0001, 4'b0000, 16'h000D, 32'h0000005A);
        n_checks++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL oor_ready: got %b want 0001", obs_ready); end
        tick();
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL oor_wr_en: got %b want 0", bus.wr_en); end
        n_checks++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL oor_err_pulse: got %b want 1", bus.err_pulse); end
        n_checks++; if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL oor_err_cnt: got %0d want 1", bus.err_cnt); end
        drive(4'b0000, 4'b0000, 16'h0, 32'h0);
        tick();
        n_checks++; if (bus.err_pulse !== 1'b0 || bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL oor_pulse_end: got p=%b c=%0d want p=0 c=1", bus.err_pulse, bus.err_cnt); end
        drive(4'b0001, 4'b0000, 16'h000C, 32'h00000011);
        tick();
        n_checks++; if (bus.wr_en !== 1'b0 || bus.err_pulse !== 1'b1 || bus.err_cnt !== 8'd2) begin
            n_fail++; $display("FAIL oor_addr12: got en=%b p=%b c=%0d want en=0 p=1 c=2", bus.wr_en, bus.err_pulse, bus.err_cnt);
        end
        drive(4'b0001, 4'b0000, 16'h000B, 32'h00000022);
        tick();
        n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'hB || bus.err_pulse !== 1'b0 || bus.err_cnt !== 8'd2) begin
            n_fail++; $display("FAIL oor_addr11: got en=%b a=%h p=%b c=%0d want en=1 a=b p=0 c=2", bus.wr_en, bus.wr_addr, bus.err_pulse, bus.err_cnt);
        end
        wr_seen = 0;
        for (int n = 0; n < 258; n++) begin
            drive(4'b0001, 4'b0000, 16'($urandom_range(15, 12)), $urandom);
            tick();
            if (bus.wr_en === 1'b1) wr_seen++;
            exp_cnt = (n + 3 > 255) ? 255 : n + 3;
            n_checks++; if (bus.err_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL oor_cnt[%0d]: got %0d want %0d", n, bus.err_cnt, exp_cnt); end
        end
        n_checks++; if (wr_seen != 0) begin n_fail++; $display("FAIL oor_no_write: got %0d writes want 0", wr_seen); end
        n_checks++; if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL oor_saturate: got %0d want 255", bus.err_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        drive(4'b0100, 4'b0100, 16'h0300, 32'h00770000);
        n_checks++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL midrst_beat1_ready: got %b want 0100", obs_ready); end
        tick();
        n_checks++; if (bus.dbg_state !== 1'b1 || bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL midrst_beat1: got st=%b en=%b want st=1 en=1", bus.dbg_state, bus.wr_en); end
        drive(4'b0100, 4'b0100, 16'h0300, 32'h00770000);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_ready: got %b want 0000", bus.req_ready); end
        n_checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'h0 || bus.wr_data !== 8'h00 || bus.grant_id !== 2'd0 || bus.err_pulse !== 1'b0 || bus.dbg_state !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got en=%b a=%h d=%h id=%0d p=%b st=%b want all 0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id, bus.err_pulse, bus.dbg_state);
        end
        @(posedge clk);
        #1;
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_no_write: got %b want 0", bus.wr_en); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_lock  = 4'b0000;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant: got %b want 0001", bus.req_ready); end
        tick();
        n_checks++; if (bus.grant_id !== 2'd0 || bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL midrst_first_write: got id=%0d en=%b want id=0 en=1", bus.grant_id, bus.wr_en); end
    endtask

    task automatic test_random();
        logic [3:0]  v, l, er;
        logic [15:0] a;
        logic [31:0] d;
        logic        e_wr, e_err;
        logic [13:0] exp_item, got_item;
        int g;
        int accepted = 0;
        int cycles   = 0;
        int max_wait = 0;
        int wait_cnt [4] = '{0, 0, 0, 0};
        int grants   [4] = '{0, 0, 0, 0};
        apply_reset();
        while (accepted < 1000 && cycles < 8000) begin
            v = 4'($urandom) | 4'($urandom);
            l = 4'($urandom);
            a = 16'($urandom);
            d = $urandom;
            drive(v, l, a, d);
            model_step(v, l, a, d, er, e_wr, e_err, g);
            n_checks++; if (obs_ready !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", cycles, obs_ready, er); end
            n_checks++; if ($countones(obs_ready) > 1) begin n_fail++; $display("FAIL rand_onehot[%0d]: got %b want at most one bit", cycles, obs_ready); end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (v[i[1:0]] && !obs_ready[i[1:0]]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            if (g >= 0) begin
                accepted++;
                grants[g]++;
            end
            tick();
            cycles++;
            n_checks++; if (bus.wr_en !== e_wr) begin n_fail++; $display("FAIL rand_wr_en[%0d]: got %b want %b", cycles, bus.wr_en, e_wr); end
            if (bus.wr_en === 1'b1) begin
                got_item = {bus.grant_id, bus.wr_addr, bus.wr_data};
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_extra_write[%0d]: got %h want no write", cycles, got_item);
                end else begin
                    exp_item = exp_q.pop_front();
                    n_checks++; if (got_item !== exp_item) begin n_fail++; $display("FAIL rand_write[%0d]: got %h want %h", cycles, got_item, exp_item); end
                end
            end
            n_checks++; if (bus.err_pulse !== e_err) begin n_fail++; $display("FAIL rand_err_pulse[%0d]: got %b want %b", cycles, bus.err_pulse, e_err); end
            n_checks++; if (bus.err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL rand_err_cnt[%0d]: got %0d want %0d", cycles, bus.err_cnt, m_err); end
        end
        n_checks++; if (accepted < 1000) begin n_fail++; $display("FAIL rand_budget: got %0d beats want 1000", accepted); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost: got %0d unwritten want 0", exp_q.size()); end
        n_checks++; if (max_wait > NUM_REQ * MAX_BURST) begin n_fail++; $display("FAIL rand_starve: got wait %0d want <= %0d", max_wait, NUM_REQ * MAX_BURST); end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_checks++; if (grants[i] == 0) begin n_fail++; $display("FAIL rand_granted[%0d]: got 0 grants want > 0", i); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_lock_drop();
        test_out_of_range();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter NUM_REGS, default 16, depth of the downstream register bank; AW = $clog2(NUM_REGS).
REQ-003 Parameter WIDTH, default 8, data width.
REQ-004 Parameter MAX_BURST, default 4, maximum consecutive beats granted to one locked requester (1..15).
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  NUM_REQ  per-requester write-request valid.
REQ-008 req_lock  input  NUM_REQ  per-requester burst-lock request, sampled with valid.
REQ-009 req_addr  input  NUM_REQ*AW  packed register addresses, requester i at [i*AW +: AW].
REQ-010 req_data  input  NUM_REQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH].
REQ-011 req_ready  output  NUM_REQ  per-requester accept; combinational; at most one bit high per cycle.
REQ-012 wr_en  output  1  registered write strobe to the register bank.
REQ-013 wr_addr  output  AW  registered write address.
REQ-014 wr_data  output  WIDTH  registered write data.
REQ-015 grant_id  output  $clog2(NUM_REQ)  registered index of the requester whose beat drives wr_*.
REQ-016 err_pulse  output  1  registered one-cycle flag: accepted beat had address >= NUM_REGS.
REQ-017 err_cnt  output  8  saturating count of out-of-range beats.

Function
REQ-018 Beat accepted for requester i when req_valid[i] && req_ready[i] in the same cycle.
REQ-019 FSM states: IDLE (no owner), LOCKED (owner held in owner_q).
REQ-020 IDLE: req_ready to the first valid requester scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ; none if no valid.
REQ-021 IDLE grant to i with req_lock[i]=1 and MAX_BURST>1 -> LOCKED next cycle, owner_q=i, beat_cnt=1; otherwise remain IDLE.
REQ-022 LOCKED: only req_ready[owner_q] may be high, asserted iff req_valid[owner_q]; other requesters wait.
REQ-023 LOCKED: each accepted beat increments beat_cnt; exit to IDLE after beat with req_lock=0 or beat_cnt reaching MAX_BURST.
REQ-024 LOCKED with req_valid[owner_q]=0 -> IDLE next cycle, no beat that cycle.
REQ-025 rr_ptr updates to (granted index + 1) mod NUM_REQ on every accepted beat; unchanged otherwise.
REQ-026 Latency: accepted beat appears on wr_en/wr_addr/wr_data/grant_id exactly one cycle later; wr_en low in all other cycles.
REQ-027 Addr >= NUM_REGS (non-power-of-2 NUM_REGS only): beat accepted, wr_en stays low, err_pulse high one cycle, err_cnt +1 saturating at 255.
REQ-028 Simultaneous valid from all requesters: exactly one ready per cycle; every requester granted within NUM_REQ*MAX_BURST cycles.
REQ-029 req_addr/req_data/req_lock of non-granted requesters shall not affect any output or state.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, rr_ptr=0, owner_q=0, beat_cnt=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0, err_pulse=0, err_cnt=0.
REQ-031 req_ready all low while rst_n low; first grant possible in first clk edge cycle after release.
REQ-032 Reset mid-burst abandons LOCKED; any beat accepted in the reset-assertion cycle is not written.

Verification
REQ-033 Reset release, req_valid=4'b1111, lock=0 -> grants 0,1,2,3,0 on consecutive cycles; wr_en high from cycle 2, grant_id follows one cycle later.
REQ-034 Requester 2 valid+lock held, req_valid=4'b0111, MAX_BURST=4 -> req_ready=4'b0100 for 4 cycles, then requester 0 granted (rr_ptr=3 wraps past idle 3).
REQ-035 Requester 1 locked, drops valid after beat 2 -> one idle cycle in LOCKED, then IDLE, round robin resumes from 2.
REQ-036 NUM_REGS=12, accepted addr 13 -> wr_en=0, err_pulse=1 one cycle, err_cnt 0->1; 260 such beats -> err_cnt=255.
REQ-037 rst_n low during LOCKED beat 2 -> all outputs zero immediately; after release, requester 0 granted first.
REQ-038 Each accepted beat (addr A, data D) -> wr_addr=A, wr_data=D next cycle; scoreboard of 1000 random beats shows no loss, duplication, or starvation.
